// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline hazard types: sequencer state, control bundle and the
// canned enable/clear patterns the sequencer selects between.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    localparam int HZ_MAX_WAIT_DFLT = 15;
    localparam int HZ_CNT_W_DFLT    = 32;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_clr;
        logic idex_clr;
        logic memwb_clr;
    } hz_ctrl_t;

    // Field order: PC, IF/ID, ID/EX, EX/MEM enables, then IF/ID, ID/EX, MEM/WB clears
    localparam hz_ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam hz_ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_HALT     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-status inputs and register-control outputs of the hazard sequencer.
// master = the sequencer, slave = the pipeline datapath it controls.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1_id;
    logic [4:0]       Rs2_id;
    logic             Rs1Used_id;
    logic             Rs2Used_id;
    logic [4:0]       Rd_ex;
    logic             DMRd_ex;
    logic             BrTaken_ex;
    logic             DMReq_mem;
    logic             DMReady;

    logic             PCEn;
    logic             IFIDEn;
    logic             IDEXEn;
    logic             EXMEMEn;
    logic             IFIDClear;
    logic             IDEXClear;
    logic             MEMWBClear;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        input  Rs1_id, Rs2_id, Rs1Used_id, Rs2Used_id, Rd_ex, DMRd_ex,
               BrTaken_ex, DMReq_mem, DMReady,
        output PCEn, IFIDEn, IDEXEn, EXMEMEn, IFIDClear, IDEXClear, MEMWBClear,
               MemTimeout, StallCount, FlushCount
    );

    modport slave (
        output Rs1_id, Rs2_id, Rs1Used_id, Rs2Used_id, Rd_ex, DMRd_ex,
               BrTaken_ex, DMReq_mem, DMReady,
        input  PCEn, IFIDEn, IDEXEn, EXMEMEn, IFIDClear, IDEXClear, MEMWBClear,
               MemTimeout, StallCount, FlushCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load sitting in EX.
// x0 is never a real dependency, so a load to x0 never stalls.
module load_use_detect (
    input  logic [4:0] Rs1_id,
    input  logic [4:0] Rs2_id,
    input  logic       Rs1Used_id,
    input  logic       Rs2Used_id,
    input  logic [4:0] Rd_ex,
    input  logic       DMRd_ex,
    output logic       LoadUse
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = Rs1Used_id && (Rs1_id == Rd_ex);
    assign rs2_hit = Rs2Used_id && (Rs2_id == Rd_ex);
    assign LoadUse = DMRd_ex && (Rd_ex != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze with watchdog,
// branch flush, load-use bubble, and saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = HZ_MAX_WAIT_DFLT,
    parameter int CNT_W    = HZ_CNT_W_DFLT
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    pipeline_hazard_ctrl_if.master hz
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    hz_state_t         state_reg;
    hz_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              timeout_reg;
    logic              timeout_next;

    logic              load_use;
    logic              frz;
    hz_ctrl_t          ctrl;
    hz_ctrl_t          ctrl_out;
    logic [1:0]        cnt_inc;     // [0] stall cycle, [1] flush event

    load_use_detect u_load_use_detect (
        .Rs1_id     (hz.Rs1_id),
        .Rs2_id     (hz.Rs2_id),
        .Rs1Used_id (hz.Rs1Used_id),
        .Rs2Used_id (hz.Rs2Used_id),
        .Rd_ex      (hz.Rd_ex),
        .DMRd_ex    (hz.DMRd_ex),
        .LoadUse    (load_use)
    );

    // A ready strobe with no request in MEM does not count as a completion.
    assign frz = (state_reg != HALT) && hz.DMReq_mem && !hz.DMReady;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        ctrl          = CTRL_NORMAL;
        cnt_inc       = 2'b00;

        case (state_reg)
            RUN, MEM_WAIT: begin
                if (frz) begin
                    ctrl          = CTRL_FREEZE;
                    cnt_inc[0]    = 1'b1;
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_next   = HALT;
                        timeout_next = 1'b1;
                    end else begin
                        state_next   = MEM_WAIT;
                    end
                end else begin
                    // The MEM_WAIT exit cycle is a full RUN cycle.
                    state_next    = RUN;
                    wait_cnt_next = '0;
                    if (hz.BrTaken_ex) begin
                        ctrl       = CTRL_FLUSH;
                        cnt_inc[1] = 1'b1;
                    end else if (load_use) begin
                        ctrl       = CTRL_LOAD_USE;
                        cnt_inc[0] = 1'b1;
                    end
                end
            end
            HALT: begin
                ctrl       = CTRL_HALT;
                cnt_inc[0] = 1'b1;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Stage registers must see bubbles, not stale enables, while reset is held.
    assign ctrl_out = Rst_n ? ctrl : CTRL_RESET;

    assign hz.PCEn       = ctrl_out.pc_en;
    assign hz.IFIDEn     = ctrl_out.ifid_en;
    assign hz.IDEXEn     = ctrl_out.idex_en;
    assign hz.EXMEMEn    = ctrl_out.exmem_en;
    assign hz.IFIDClear  = ctrl_out.ifid_clr;
    assign hz.IDEXClear  = ctrl_out.idex_clr;
    assign hz.MEMWBClear = ctrl_out.memwb_clr;
    assign hz.MemTimeout = timeout_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign hz.StallCount = g_cnt[0].cnt_reg;
    assign hz.FlushCount = g_cnt[1].cnt_reg;

endmodule
